// File: rtl/id_issue_ctrl_pkg.sv
// Shared definitions for the ID-stage issue controller.
// Holds the ID fetch-hold FSM encoding, default widths and the zero-register index.
// Imported by id_issue_ctrl and id_fwd_mux.
package id_issue_ctrl_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_AW   = 5;
    localparam int DEF_NFWD = 3;
    localparam int DEF_CW   = 16;

    // Architectural r0: never written, always reads as zero.
    localparam int ZERO_REG = 0;

    // RUN:  ID instruction word comes straight from the instruction SRAM.
    // HOLD: ID is stalled and the SRAM output may have moved on, so the word
    //       captured on the first stall edge is presented instead.
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } issue_state_t;

endpackage

// File: rtl/id_fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight write to addr, else the regfile value.
// Latency: purely combinational, zero cycles.
// Ports: addr / rf_rdata in, per-source fwd_* vectors in; data, hit, load_hit out.
module id_fwd_mux
    import id_issue_ctrl_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int NFWD = DEF_NFWD
) (
    input  logic [AW-1:0]      addr,
    input  logic [DW-1:0]      rf_rdata,
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD-1:0]    fwd_is_load,
    input  logic [NFWD*AW-1:0] fwd_waddr,
    input  logic [NFWD*DW-1:0] fwd_wdata,
    output logic [DW-1:0]      data,
    output logic               hit,
    output logic               load_hit
);

    always_comb begin
        data     = rf_rdata;
        hit      = 1'b0;
        load_hit = 1'b0;
        // Walk oldest to youngest so the youngest (lowest index) match is
        // the last assignment and therefore wins.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[i*AW +: AW] == addr)) begin
                data     = fwd_wdata[i*DW +: DW];
                hit      = 1'b1;
                load_hit = fwd_is_load[i];
            end
        end
        // r0 is hard-wired: a pending write to it must neither forward nor stall.
        if (addr == AW'(ZERO_REG)) begin
            data     = '0;
            hit      = 1'b0;
            load_hit = 1'b0;
        end
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue control: ID pipeline register, instruction hold across stalls,
// operand forwarding and load-use stall detection with a saturating hazard counter.
// Ports: IF pc/valid + SRAM data in, decoder/regfile/forwarding inputs in;
//        id_valid/id_pc/id_inst, rs/rt addresses, forwarded operands, stallreq, hazard_cnt out.
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int NFWD = DEF_NFWD,
    parameter int CW   = DEF_CW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               id_stall,
    input  logic               if_valid,
    input  logic [31:0]        if_pc,
    input  logic [31:0]        inst_rdata,
    input  logic               use_rs,
    input  logic               use_rt,
    input  logic [DW-1:0]      rf_rdata1,
    input  logic [DW-1:0]      rf_rdata2,
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD-1:0]    fwd_is_load,
    input  logic [NFWD*AW-1:0] fwd_waddr,
    input  logic [NFWD*DW-1:0] fwd_wdata,
    output logic               id_valid,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_inst,
    output logic [AW-1:0]      rs_addr,
    output logic [AW-1:0]      rt_addr,
    output logic [DW-1:0]      opnd1,
    output logic [DW-1:0]      opnd2,
    output logic               stallreq,
    output logic [CW-1:0]      hazard_cnt
);

    issue_state_t state, state_nxt;
    logic         capture;
    logic [31:0]  inst_hold;
    logic         rs_hit, rs_load_hit;
    logic         rt_hit, rt_load_hit;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        id_inst   = '0;
        unique case (state)
            RUN: begin
                if (id_stall && !flush) begin
                    state_nxt = HOLD;
                    capture   = 1'b1;
                end
                if (id_valid) id_inst = inst_rdata;
            end
            HOLD: begin
                if (!id_stall || flush) state_nxt = RUN;
                if (id_valid) id_inst = inst_hold;
            end
            default: state_nxt = RUN;
        endcase
    end

    // ---------------- ID pipeline register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid  <= 1'b0;
            id_pc     <= '0;
            inst_hold <= '0;
        end else begin
            if (flush) begin
                id_valid <= 1'b0;
                id_pc    <= '0;
            end else if (!id_stall) begin
                id_valid <= if_valid;
                id_pc    <= if_pc;
            end
            if (capture) inst_hold <= inst_rdata;
        end
    end

    // ---------------- Operand forwarding ----------------
    assign rs_addr = AW'(id_inst[25:21]);
    assign rt_addr = AW'(id_inst[20:16]);

    id_fwd_mux #(.DW(DW), .AW(AW), .NFWD(NFWD)) u_fwd_rs (
        .addr        (rs_addr),
        .rf_rdata    (rf_rdata1),
        .fwd_we      (fwd_we),
        .fwd_is_load (fwd_is_load),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .data        (opnd1),
        .hit         (rs_hit),
        .load_hit    (rs_load_hit)
    );

    id_fwd_mux #(.DW(DW), .AW(AW), .NFWD(NFWD)) u_fwd_rt (
        .addr        (rt_addr),
        .rf_rdata    (rf_rdata2),
        .fwd_we      (fwd_we),
        .fwd_is_load (fwd_is_load),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .data        (opnd2),
        .hit         (rt_hit),
        .load_hit    (rt_load_hit)
    );

    // Only the youngest match per operand is considered, so a younger ALU
    // result to the same register hides an older load (no stall).
    assign stallreq = id_valid && !flush &&
                      ((use_rs && rs_hit && rs_load_hit) ||
                       (use_rt && rt_hit && rt_load_hit));

    // ---------------- Hazard counter (saturating) ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hazard_cnt <= '0;
        end else if (stallreq && (hazard_cnt != {CW{1'b1}})) begin
            hazard_cnt <= hazard_cnt + CW'(1);
        end
    end

endmodule

// File: doc/id_issue_ctrl.md
ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, operand data width.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter NFWD, default 3, forwarding sources; index 0 youngest (EX), rising index older (MEM, WB, ...).
REQ-004 SHALL have parameter CW, default 16, hazard-cycle counter width.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 flush  in  1  discard the instruction in ID.
REQ-008 id_stall  in  1  hold ID stage (stall[1] from pipeline control).
REQ-009 if_valid  in  1  IF presents a fetched PC.
REQ-010 if_pc  in  32  PC of fetched instruction.
REQ-011 inst_rdata  in  32  synchronous instruction SRAM data, valid the cycle after if_pc is captured.
REQ-012 use_rs, use_rt  in  1 each  decoder flags: instruction reads rs / rt.
REQ-013 rf_rdata1, rf_rdata2  in  DW each  regfile data for rs / rt.
REQ-014 fwd_we  in  NFWD  per-source write enable.
REQ-015 fwd_is_load  in  NFWD  per-source: result not yet available (load).
REQ-016 fwd_waddr  in  NFWD*AW  packed write addresses, source i at [i*AW +: AW].
REQ-017 fwd_wdata  in  NFWD*DW  packed write data, same packing.
REQ-018 id_valid  out  1  ID holds a live instruction.
REQ-019 id_pc, id_inst  out  32 each  PC and instruction in ID.
REQ-020 rs_addr, rt_addr  out  AW each  inst[25:21], inst[20:16], to regfile.
REQ-021 opnd1, opnd2  out  DW each  forwarded rs / rt operands.
REQ-022 stallreq  out  1  load-use stall request to pipeline control.
REQ-023 hazard_cnt  out  CW  count of cycles stallreq was asserted.

Function
REQ-024 Edge with flush=1: id_valid<=0, id_pc<=0, FSM<=RUN (flush beats id_stall).
REQ-025 Edge with flush=0, id_stall=0: id_valid<=if_valid, id_pc<=if_pc.
REQ-026 Edge with flush=0, id_stall=1: id_valid, id_pc unchanged.
REQ-027 FSM states RUN, HOLD; RUN->HOLD on edge with id_stall=1 & flush=0, capturing inst_rdata into inst_hold; HOLD->RUN on edge with id_stall=0 or flush=1; HOLD does not re-capture.
REQ-028 id_inst = 0 when id_valid=0; else inst_rdata in RUN, inst_hold in HOLD.
REQ-029 opnd1 = fwd_wdata[i] for lowest i with fwd_we[i]=1 and fwd_waddr[i]==rs_addr; else rf_rdata1; opnd2 likewise for rt_addr.
REQ-030 Address 0 SHALL never match; operand for register 0 is always 0.
REQ-031 stallreq = id_valid & !flush & exists i: fwd_we[i] & fwd_is_load[i] & waddr!=0 & ((use_rs & waddr==rs_addr) | (use_rt & waddr==rt_addr)), considering only the lowest matching i per operand.
REQ-032 A younger non-load match shadows an older load match to the same register (no stall).
REQ-033 hazard_cnt increments by 1 each edge with stallreq=1, saturates at all-ones, never wraps.
REQ-034 All outputs other than id_inst/opnd*/stallreq/rs_addr/rt_addr are registered; forwarding and stallreq are combinational, zero latency.

Reset
REQ-035 rst=0 SHALL immediately force id_valid=0, id_pc=0, inst_hold=0, FSM=RUN, hazard_cnt=0, independent of clk.
REQ-036 Reset during HOLD discards inst_hold; first post-reset instruction comes from inst_rdata.

Structure
REQ-037 Shared package holds FSM state encoding (RUN, HOLD), default DW/AW/NFWD/CW and the zero-register constant.
REQ-038 One sub-module, id_fwd_mux, instanced twice (rs, rt): priority match returning data, hit and load-hit.

Verification
REQ-039 if_valid=1, if_pc=0xBFC00000, inst_rdata=0x3C011234 next cycle -> id_valid=1, id_pc=0xBFC00000, id_inst=0x3C011234.
REQ-040 id_stall=1 for 3 cycles, inst_rdata changes to 0xDEADBEEF -> id_inst stays at value captured on first hold edge; resumes inst_rdata after release.
REQ-041 rs=3, fwd_we=3'b111, waddr={3,3,3}, wdata={0x33,0x22,0x11} -> opnd1=0x11; rs=0 with all waddr=0 -> opnd1=0.
REQ-042 fwd0 load to r5, use_rt=1, rt=5 -> stallreq=1, hazard_cnt +1 per cycle; same with use_rt=0 -> stallreq=0.
REQ-043 flush and id_stall both 1 in HOLD -> next cycle id_valid=0, FSM RUN; rst=0 mid-cycle -> outputs zero before next edge.
REQ-044 CW=4, stallreq held 20 cycles -> hazard_cnt=15.
